adder_pipe: RTL and testbench

- Parametrised, pipelined successor of the team's registered 4-bit adder.
- Adds two unsigned WIDTH-bit operands under a valid/ready handshake, with a fixed, configurable latency.
- A per-transaction mode bit selects plain add or running accumulate into an internal accumulator.
- Sits between an operand producer and a result consumer that may apply backpressure.

---
 rtl/adder_pipe_if.sv | 28 ++
 rtl/adder_pipe.sv | 74 +++++++
 tb/tb_adder_pipe.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe.
// The master side is the producer/consumer; the slave side is the adder.
interface adder_pipe_if #(
    parameter int WIDTH = 4
);
    localparam int OUT_W = WIDTH + 3;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] sum;
    logic             ovf;

    modport master (
        output in_valid, a, b, mode, clear, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, a, b, mode, clear, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add / accumulate unit with valid/ready handshake and a global stall.
// Arithmetic happens at accept; the remaining stages only delay the result.
module adder_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input logic         clk,
    input logic         rst,
    adder_pipe_if.slave bus
);
    localparam int OUT_W = WIDTH + 3;
    localparam int SUM_W = OUT_W + 1;

    logic             w_stall;
    logic             w_accept;
    logic [OUT_W-1:0] w_acc_base;
    logic [OUT_W-1:0] w_plain;
    logic [SUM_W-1:0] w_acc_sum;
    logic [OUT_W-1:0] w_result;

    logic [OUT_W-1:0] r_acc;
    logic             r_ovf;
    logic [OUT_W-1:0] r_data [STAGES];
    logic [STAGES-1:0] r_vld;

    assign w_stall      = r_vld[STAGES-1] && !bus.out_ready;
    assign bus.in_ready = !w_stall;
    assign w_accept     = bus.in_valid && !w_stall;

    // clear takes effect before a same-edge accumulate, so the base is zero then
    assign w_acc_base = bus.clear ? '0 : r_acc;
    assign w_plain    = OUT_W'(bus.a) + OUT_W'(bus.b);
    assign w_acc_sum  = SUM_W'(w_acc_base) + SUM_W'(bus.a) + SUM_W'(bus.b);
    assign w_result   = bus.mode ? w_acc_sum[OUT_W-1:0] : w_plain;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept && bus.mode) begin
            r_acc <= w_acc_sum[OUT_W-1:0];
            r_ovf <= (r_ovf && !bus.clear) || w_acc_sum[OUT_W];
        end else if (bus.clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end
    end

    // NOTE: the data registers are reset too, because sum must read zero
    // straight out of reset, not just out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
            end
        end else if (!w_stall) begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_data[0] <= w_result;
            end
            for (int i = 1; i < STAGES; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.sum       = r_data[STAGES-1];
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench: directed cases plus random traffic against a queue-based
// reference model on a WIDTH=4/STAGES=2 instance, and latency/wrap checks on 8-bit variants.
module tb_adder_pipe;
    localparam int MOD4 = 128;   // 2^(4+3)
    localparam int MOD8 = 2048;  // 2^(8+3)

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_pipe_if #(.WIDTH(4)) bus ();
    adder_pipe_if #(.WIDTH(8)) b1 ();
    adder_pipe_if #(.WIDTH(8)) b4 ();

    adder_pipe #(.WIDTH(4), .STAGES(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
    adder_pipe #(.WIDTH(8), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    adder_pipe #(.WIDTH(8), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    int n_cmp = 0;
    int n_err = 0;

    int   q[$];
    int   m_acc = 0;
    logic m_ovf = 1'b0;
    logic hold_pending = 1'b0;
    int   hold_sum = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle on the main instance: check state left by the previous edge,
    // drive inputs, then advance the reference model for the coming edge.
    task automatic step(input logic v, input int av, input int bv, input logic m,
                        input logic c, input logic ordy);
        logic exp_rdy;
        int   t;
        @(negedge clk);
        check("ovf", 32'(bus.ovf), 32'(m_ovf));
        if (hold_pending) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_sum", 32'(bus.sum), 32'(hold_sum));
        end
        bus.in_valid  = v;
        bus.a         = 4'(av);
        bus.b         = 4'(bv);
        bus.mode      = m;
        bus.clear     = c;
        bus.out_ready = ordy;
        #1;
        exp_rdy = !(bus.out_valid && !ordy);
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (bus.out_valid && ordy) begin
            check("pop_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) check("sum", 32'(bus.sum), 32'(q.pop_front()));
        end
        hold_pending = bus.out_valid && !ordy;
        hold_sum     = int'(bus.sum);
        if (c) begin
            m_acc = 0;
            m_ovf = 1'b0;
        end
        if (v && exp_rdy) begin
            if (m) begin
                t = m_acc + av + bv;
                if (t >= MOD4) m_ovf = 1'b1;
                m_acc = t % MOD4;
                q.push_back(m_acc);
            end else begin
                q.push_back(av + bv);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int   lat1, lat4, s1, s4, i1, i4, e_acc;
        int   exp8 [5];
        logic e_ovf;

        {bus.in_valid, bus.mode, bus.clear, bus.a, bus.b} = '0;
        {b1.in_valid, b1.mode, b1.clear, b1.a, b1.b} = '0;
        {b4.in_valid, b4.mode, b4.clear, b4.a, b4.b} = '0;
        bus.out_ready = 1'b1;
        b1.out_ready  = 1'b1;
        b4.out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        // Plain add, latency 2: valid only after the second edge
        step(1'b1, 15, 15, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("lat_edge0", 32'(bus.out_valid), 32'd0);
        step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("lat_edge1_valid", 32'(bus.out_valid), 32'd1);
        check("lat_edge1_sum", 32'(bus.sum), 32'd30);
        step(1'b1, 1, 1, 1'b1, 1'b0, 1'b1);
        drain();

        // Accumulate wrap, then clear
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        repeat (5) step(1'b1, 15, 15, 1'b1, 1'b0, 1'b1);
        drain();
        check("ovf_set", 32'(bus.ovf), 32'd1);
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 0, 0, 1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure with in_valid held high
        step(1'b1, 1, 2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 3, 4, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 5, 6, 1'b0, 1'b0, 1'b0);
        step(1'b1, 7, 8, 1'b0, 1'b0, 1'b1);
        drain();

        // Clear coinciding with an accumulate accept
        step(1'b1, 15, 15, 1'b1, 1'b1, 1'b1);
        step(1'b1, 10, 10, 1'b1, 1'b0, 1'b1);
        step(1'b1, 3, 4, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1, 0, 1'b1, 1'b0, 1'b1);
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 3) != 0));
        end
        drain();

        // Asynchronous reset with two results in flight and ovf set
        step(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
        repeat (5) step(1'b1, 15, 15, 1'b1, 1'b0, 1'b1);
        drain();
        step(1'b1, 5, 5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 6, 6, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid), 32'd0);
        check("arst_sum", 32'(bus.sum), 32'd0);
        check("arst_ovf", 32'(bus.ovf), 32'd0);
        check("arst_ready", 32'(bus.in_ready), 32'd1);
        q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        hold_pending = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 2, 2, 1'b1, 1'b0, 1'b1);
        drain();

        // WIDTH=8 with STAGES=1 and STAGES=4: latency and wrap at 2^11
        @(negedge clk);
        {b1.in_valid, b1.a, b1.b, b1.mode} = {1'b1, 8'd255, 8'd255, 1'b0};
        {b4.in_valid, b4.a, b4.b, b4.mode} = {1'b1, 8'd255, 8'd255, 1'b0};
        lat1 = 0; lat4 = 0; s1 = 0; s4 = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            b1.in_valid = 1'b0;
            b4.in_valid = 1'b0;
            if (b1.out_valid && lat1 == 0) begin lat1 = k; s1 = int'(b1.sum); end
            if (b4.out_valid && lat4 == 0) begin lat4 = k; s4 = int'(b4.sum); end
        end
        check("s1_latency", 32'(lat1), 32'd1);
        check("s1_sum", 32'(s1), 32'd510);
        check("s4_latency", 32'(lat4), 32'd4);
        check("s4_sum", 32'(s4), 32'd510);

        e_acc = 0;
        e_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            e_acc = e_acc + 510;
            if (e_acc >= MOD8) begin e_ovf = 1'b1; e_acc = e_acc - MOD8; end
            exp8[i] = e_acc;
        end
        i1 = 0; i4 = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (b1.out_valid) begin
                if (i1 < 5) check("burst_s1", 32'(b1.sum), 32'(exp8[i1]));
                i1++;
            end
            if (b4.out_valid) begin
                if (i4 < 5) check("burst_s4", 32'(b4.sum), 32'(exp8[i4]));
                i4++;
            end
            b1.in_valid = (k < 5);
            b1.mode     = 1'b1;
            b4.in_valid = (k < 5);
            b4.mode     = 1'b1;
        end
        check("burst_count_s1", 32'(i1), 32'd5);
        check("burst_count_s4", 32'(i4), 32'd5);
        check("burst_ovf_s1", 32'(b1.ovf), 32'(e_ovf));
        check("burst_ovf_s4", 32'(b4.ovf), 32'(e_ovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
